// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EX operands, forwarding feedback and EX/MEM results of the execute stage
interface exe_stage_if;
  logic        fwd_en, status_update, branch_en, mem_read_in, mem_write_in, wb_en_in, imm;
  logic [3:0]  exe_cmd, reg_dest_in, status_in, src1_idx, src2_idx;
  logic [11:0] shifter_operand;
  logic [23:0] signed_imm;
  logic [31:0] pc_in, rn_in, rm_in;
  logic [3:0]  mem_fwd_dest, wb_dest;
  logic        mem_fwd_wb_en, wb_wb_en;
  logic [31:0] wb_value;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_reg;
  logic [31:0] alu_result, store_data;
  logic [3:0]  reg_dest;
  logic        mem_read, mem_write, wb_en;
  modport slave (
    input  fwd_en, status_update, branch_en, mem_read_in, mem_write_in, wb_en_in, imm,
           exe_cmd, reg_dest_in, status_in, src1_idx, src2_idx, shifter_operand, signed_imm,
           pc_in, rn_in, rm_in, mem_fwd_dest, mem_fwd_wb_en, wb_dest, wb_wb_en, wb_value,
    output branch_taken, branch_addr, status_reg, alu_result, store_data, reg_dest,
           mem_read, mem_write, wb_en
  );
  modport master (
    output fwd_en, status_update, branch_en, mem_read_in, mem_write_in, wb_en_in, imm,
           exe_cmd, reg_dest_in, status_in, src1_idx, src2_idx, shifter_operand, signed_imm,
           pc_in, rn_in, rm_in, mem_fwd_dest, mem_fwd_wb_en, wb_dest, wb_wb_en, wb_value,
    input  branch_taken, branch_addr, status_reg, alu_result, store_data, reg_dest,
           mem_read, mem_write, wb_en
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage with forwarding, shifter, ALU, NZCV register and EX/MEM register
module exe_stage #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  exe_stage_if.slave bus
);
  logic [WIDTH-1:0] a, src2, val2, shifted, asr, bb, res;
  logic [2*WIDTH-1:0] imm_rot, ror_dbl;
  logic [WIDTH:0] sum;
  logic [4:0] sh;
  logic [1:0] typ;
  logic cin, arith, sub, valid, n, z, c, v;
  always_comb begin
    a = bus.fwd_en && bus.mem_fwd_wb_en && bus.mem_fwd_dest == bus.src1_idx ? bus.alu_result :
        bus.fwd_en && bus.wb_wb_en && bus.wb_dest == bus.src1_idx ? bus.wb_value : bus.rn_in;
    src2 = bus.fwd_en && bus.mem_fwd_wb_en && bus.mem_fwd_dest == bus.src2_idx ? bus.alu_result :
           bus.fwd_en && bus.wb_wb_en && bus.wb_dest == bus.src2_idx ? bus.wb_value : bus.rm_in;
    sh = bus.shifter_operand[11:7];
    typ = bus.shifter_operand[6:5];
    imm_rot = {2{24'b0, bus.shifter_operand[7:0]}} >> {bus.shifter_operand[11:8], 1'b0};
    ror_dbl = {src2, src2} >> sh;
    asr = $signed(src2) >>> sh;
    shifted = typ == 2'b00 ? src2 << sh : typ == 2'b01 ? src2 >> sh : typ == 2'b10 ? asr : ror_dbl[WIDTH-1:0];
    val2 = bus.imm ? imm_rot[WIDTH-1:0] :
           (bus.mem_read_in | bus.mem_write_in) ? {{(WIDTH-12){1'b0}}, bus.shifter_operand} : shifted;
    sub = bus.exe_cmd == 4'b0100 || bus.exe_cmd == 4'b0101;
    arith = sub || bus.exe_cmd == 4'b0010 || bus.exe_cmd == 4'b0011;
    // ADC and SBC both add the raw carry; SUB supplies the +1 of two's complement
    cin = bus.exe_cmd == 4'b0010 ? 1'b0 : bus.exe_cmd == 4'b0100 ? 1'b1 : bus.status_in[1];
    bb = sub ? ~val2 : val2;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    valid = arith || bus.exe_cmd == 4'b0001 || bus.exe_cmd == 4'b1001 || bus.exe_cmd == 4'b0110 ||
            bus.exe_cmd == 4'b0111 || bus.exe_cmd == 4'b1000;
    res = arith ? sum[WIDTH-1:0] :
          bus.exe_cmd == 4'b0001 ? val2 :
          bus.exe_cmd == 4'b1001 ? ~val2 :
          bus.exe_cmd == 4'b0110 ? a & val2 :
          bus.exe_cmd == 4'b0111 ? a | val2 :
          bus.exe_cmd == 4'b1000 ? a ^ val2 : '0;
    n = res[WIDTH-1];
    z = res == '0;
    c = arith ? sum[WIDTH] : bus.status_reg[1];
    v = arith ? (sub ? a[WIDTH-1] != val2[WIDTH-1] : a[WIDTH-1] == val2[WIDTH-1]) && res[WIDTH-1] != a[WIDTH-1]
              : bus.status_reg[0];
  end
  assign bus.branch_taken = bus.branch_en;
  assign bus.branch_addr = bus.pc_in + {{6{bus.signed_imm[23]}}, bus.signed_imm, 2'b00};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.status_reg <= '0;
      bus.alu_result <= '0;
      bus.store_data <= '0;
      bus.reg_dest <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.wb_en <= 1'b0;
    end else begin
      if (bus.status_update && valid) bus.status_reg <= {n, z, c, v};
      bus.alu_result <= res;
      bus.store_data <= src2;
      bus.reg_dest <= bus.reg_dest_in;
      bus.mem_read <= bus.mem_read_in;
      bus.mem_write <= bus.mem_write_in;
      bus.wb_en <= bus.wb_en_in;
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors against an arithmetic reference model of the execute stage
module tb_exe_stage;
  logic clk = 0, reset = 1, chk_en = 0;
  int total = 0, bad = 0;
  exe_stage_if bus();
  exe_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_val2(logic i, logic memop, logic [11:0] so, logic [31:0] b);
    logic [31:0] x;
    if (i) begin
      x = {24'b0, so[7:0]};
      for (int k = 0; k < 2 * int'(so[11:8]); k++) x = {x[0], x[31:1]};
      return x;
    end
    if (memop) return {20'b0, so};
    x = b;
    for (int k = 0; k < int'(so[11:7]); k++)
      case (so[6:5])
        2'd0: x = x * 2;
        2'd1: x = x / 2;
        2'd2: x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    return x;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, b, input logic cin,
                                input logic [3:0] old, output logic [31:0] r, output logic [3:0] f,
                                output logic ok);
    longint ua, ub, u, s, sa, sb, bor;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = old[1]; v = old[0]; ok = 1; r = 0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        bor = (cmd == 4'b0011) ? longint'(cin) : 0;
        u = ua + ub + bor; s = sa + sb + bor;
        r = u[31:0]; c = u >= 64'sh100000000;
        v = s > 64'sh7FFFFFFF || s < -64'sh80000000;
      end
      4'b0100, 4'b0101: begin
        bor = (cmd == 4'b0101) ? longint'(!cin) : 0;
        u = ua - ub - bor; s = sa - sb - bor;
        r = u[31:0]; c = ua >= ub + bor;
        v = s > 64'sh7FFFFFFF || s < -64'sh80000000;
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: ok = 0;
    endcase
    f = {r[31], r == 0, c, v};
  endfunction

  logic [31:0] e_alu, e_st, ta, tb2, tv, tr;
  logic [3:0] e_flags, e_dest, tf;
  logic e_mr, e_mw, e_wb, tok;
  always @(posedge clk or posedge reset)
    if (reset) begin
      e_alu <= 0; e_st <= 0; e_flags <= 0; e_dest <= 0; e_mr <= 0; e_mw <= 0; e_wb <= 0;
    end else begin
      ta = bus.fwd_en && bus.mem_fwd_wb_en && bus.mem_fwd_dest == bus.src1_idx ? e_alu :
           bus.fwd_en && bus.wb_wb_en && bus.wb_dest == bus.src1_idx ? bus.wb_value : bus.rn_in;
      tb2 = bus.fwd_en && bus.mem_fwd_wb_en && bus.mem_fwd_dest == bus.src2_idx ? e_alu :
            bus.fwd_en && bus.wb_wb_en && bus.wb_dest == bus.src2_idx ? bus.wb_value : bus.rm_in;
      tv = m_val2(bus.imm, bus.mem_read_in | bus.mem_write_in, bus.shifter_operand, tb2);
      m_alu(bus.exe_cmd, ta, tv, bus.status_in[1], e_flags, tr, tf, tok);
      e_alu <= tr; e_st <= tb2; e_dest <= bus.reg_dest_in;
      e_mr <= bus.mem_read_in; e_mw <= bus.mem_write_in; e_wb <= bus.wb_en_in;
      if (bus.status_update && tok) e_flags <= tf;
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("alu_result", bus.alu_result, e_alu);
      chk("store_data", bus.store_data, e_st);
      chk("status_reg", 32'(bus.status_reg), 32'(e_flags));
      chk("reg_dest", 32'(bus.reg_dest), 32'(e_dest));
      chk("ctrl", {29'b0, bus.mem_read, bus.mem_write, bus.wb_en}, {29'b0, e_mr, e_mw, e_wb});
      chk("branch_taken", 32'(bus.branch_taken), 32'(bus.branch_en));
      chk("branch_addr", bus.branch_addr, bus.pc_in + 32'(4 * longint'($signed(bus.signed_imm))));
    end

  task automatic clr();
    {bus.fwd_en, bus.status_update, bus.branch_en, bus.mem_read_in, bus.mem_write_in, bus.wb_en_in, bus.imm} = '0;
    {bus.exe_cmd, bus.reg_dest_in, bus.status_in, bus.src1_idx, bus.src2_idx} = '0;
    bus.shifter_operand = 0; bus.signed_imm = 0;
    bus.pc_in = 0; bus.rn_in = 0; bus.rm_in = 0;
    bus.mem_fwd_dest = 0; bus.mem_fwd_wb_en = 0; bus.wb_dest = 0; bus.wb_wb_en = 0; bus.wb_value = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    step(); step();
    chk_en = 1;
    chk("rst_alu", bus.alu_result, 32'h0);
    chk("rst_status", 32'(bus.status_reg), 32'h0);
    reset = 0;
    clr(); bus.rn_in = 32'h7FFFFFFF; bus.imm = 1; bus.shifter_operand = 12'h001;
    bus.exe_cmd = 4'b0010; bus.status_update = 1; bus.wb_en_in = 1; bus.reg_dest_in = 4'd2;
    step();
    chk("adds_res", bus.alu_result, 32'h80000000);
    chk("adds_nzcv", 32'(bus.status_reg), 32'b1001);
    clr(); bus.rn_in = 5; bus.rm_in = 5; bus.src2_idx = 1; bus.exe_cmd = 4'b0100; bus.status_update = 1;
    step();
    chk("subs_res", bus.alu_result, 32'h0);
    chk("subs_nzcv", 32'(bus.status_reg), 32'b0110);
    clr(); bus.imm = 1; bus.shifter_operand = 12'h011; bus.exe_cmd = 4'b0001; bus.wb_en_in = 1; bus.reg_dest_in = 3;
    step();
    chk("mov_imm", bus.alu_result, 32'h11);
    clr(); bus.fwd_en = 1; bus.src1_idx = 3; bus.mem_fwd_dest = 3; bus.mem_fwd_wb_en = 1;
    bus.wb_dest = 3; bus.wb_wb_en = 1; bus.wb_value = 32'h22; bus.rn_in = 32'h99;
    bus.exe_cmd = 4'b0010; bus.imm = 1;
    step();
    chk("fwd_mem_prio", bus.alu_result, 32'h11);
    bus.mem_fwd_dest = 4;
    step();
    chk("fwd_wb", bus.alu_result, 32'h22);
    bus.fwd_en = 0;
    step();
    chk("fwd_off", bus.alu_result, 32'h99);
    clr(); bus.rm_in = 32'h80000000; bus.src2_idx = 7; bus.exe_cmd = 4'b0001; bus.shifter_operand = 12'h240;
    step();
    chk("asr4", bus.alu_result, 32'hF8000000);
    chk("store_fwd", bus.store_data, 32'h80000000);
    clr(); bus.imm = 1; bus.shifter_operand = 12'h4FF; bus.exe_cmd = 4'b0001;
    step();
    chk("imm_rot", bus.alu_result, 32'hFF000000);
    clr(); bus.pc_in = 32'h100; bus.signed_imm = 24'hFFFFFE; bus.branch_en = 1;
    bus.rn_in = 1; bus.imm = 1; bus.shifter_operand = 12'h001; bus.exe_cmd = 4'b0011; bus.status_in = 4'b0010;
    #1;
    chk("br_taken", 32'(bus.branch_taken), 32'h1);
    chk("br_addr", bus.branch_addr, 32'hF8);
    step();
    chk("adc", bus.alu_result, 32'h3);
    clr(); bus.rn_in = 10; bus.rm_in = 3; bus.exe_cmd = 4'b0101; bus.status_in = 4'b0000; bus.status_update = 1;
    step();
    chk("sbc", bus.alu_result, 32'h6);
    clr(); bus.rn_in = 32'h1000; bus.shifter_operand = 12'hFFF; bus.exe_cmd = 4'b0010;
    bus.mem_read_in = 1; bus.wb_en_in = 1; bus.reg_dest_in = 9;
    step();
    chk("ldr_addr", bus.alu_result, 32'h1FFF);
    clr(); bus.rn_in = 32'h20; bus.rm_in = 32'hABCD; bus.shifter_operand = 12'h004; bus.exe_cmd = 4'b0010;
    bus.mem_write_in = 1;
    step();
    chk("str_data", bus.store_data, 32'hABCD);
    clr(); bus.rm_in = 32'h0000_00F1; bus.shifter_operand = 12'h260; bus.exe_cmd = 4'b1000; bus.rn_in = 32'hFFFF_0000;
    step();
    chk("eor_ror4", bus.alu_result, 32'hEFFF_000F);
    clr(); bus.rm_in = 32'h8000_0001; bus.shifter_operand = 12'h0A0; bus.exe_cmd = 4'b1001; bus.status_update = 1;
    step();
    chk("mvn_lsr1", bus.alu_result, 32'hBFFF_FFFF);
    clr(); bus.rm_in = 32'h0000_0003; bus.shifter_operand = 12'hF80; bus.exe_cmd = 4'b0111; bus.rn_in = 32'h10;
    step();
    chk("orr_lsl31", bus.alu_result, 32'h8000_0010);
    clr(); bus.rn_in = 32'h0F0F; bus.rm_in = 32'h00FF; bus.exe_cmd = 4'b0110; bus.status_update = 1;
    step();
    chk("and", bus.alu_result, 32'h000F);
    clr(); bus.rn_in = 7; bus.exe_cmd = 4'b1111; bus.status_update = 1;
    step();
    chk("bad_cmd", bus.alu_result, 32'h0);
    clr(); bus.pc_in = 32'h10; bus.signed_imm = 24'h800000; bus.branch_en = 1;
    #1;
    chk("br_wrap", bus.branch_addr, 32'hFE00_0010);
    clr(); bus.rn_in = 32'h80000000; bus.imm = 1; bus.exe_cmd = 4'b0100; bus.status_update = 1; bus.wb_en_in = 1;
    step();
    chk("pre_rst_status", 32'(bus.status_reg), 32'b1010);
    chk("pre_rst_wb", 32'(bus.wb_en), 32'h1);
    reset = 1;
    #1;
    chk("rst_async", {bus.alu_result[27:0], bus.status_reg}, 32'h0);
    chk("rst_ctrl", {25'b0, bus.reg_dest, bus.mem_read, bus.mem_write, bus.wb_en}, 32'h0);
    chk("rst_store", bus.store_data, 32'h0);
    step();
    reset = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
